// File: rtl/irq_pkg.sv
// Shared types and register map for the interrupt controller.
// Imported by irq_sync_edge and irq_controller.
package irq_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_REQ     = 2'd1;
   localparam state_t ST_SERVICE = 2'd2;

   localparam logic [1:0] ADDR_MASK   = 2'd0;
   localparam logic [1:0] ADDR_PEND   = 2'd1;
   localparam logic [1:0] ADDR_CAUSE  = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt source: multi-flop synchronizer, then a registered
// rising-edge detector that ignores a level already high at reset.
module irq_sync_edge
   import irq_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic irq,
   output logic rise
);

   localparam int LAST = SYNC_STAGES - 1;

   logic [LAST:0] sync_q;
   logic [LAST:0] vld_q;
   logic          edge_q;
   logic          armed_q;

   // armed_q only sets once a real, fully synchronized low was seen
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         vld_q   <= '0;
         edge_q  <= 1'b0;
         armed_q <= 1'b0;
         rise    <= 1'b0;
      end else begin
         sync_q  <= {sync_q[LAST-1:0], irq};
         vld_q   <= {vld_q[LAST-1:0], 1'b1};
         edge_q  <= sync_q[LAST];
         armed_q <= armed_q | (vld_q[LAST] & ~sync_q[LAST]);
         rise    <= sync_q[LAST] & ~edge_q & armed_q;
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Single-level interrupt controller: edge capture into PENDING,
// lowest-index priority, REQ/ack/eret handshake with the core.
module irq_controller
   import irq_pkg::*;
#(
   parameter int NUM_SRC     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] irq_in,
   output logic               irq_req,
   output logic [4:0]         irq_id,
   input  logic               irq_ack,
   input  logic               irq_eret,
   input  logic               wr_en,
   input  logic [1:0]         addr,
   input  logic [31:0]        wr_data,
   output logic [31:0]        rd_data
);

   state_t             state;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] mask_q;
   logic               status_q;
   logic [NUM_SRC-1:0] elig;
   logic               any_elig;
   logic [4:0]         win_id;
   logic               ack_fire;
   logic [NUM_SRC-1:0] ack_clr;
   logic [NUM_SRC-1:0] w1c;
   logic [31:0]        mask_w;
   logic [31:0]        pend_w;
   logic               unused_wr;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      irq_sync_edge #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
         .clk  (clk),
         .rst_n(rst_n),
         .irq  (irq_in[g]),
         .rise (rise[g])
      );
   end

   assign elig     = pending & mask_q & {NUM_SRC{status_q}};
   assign any_elig = |elig;
   assign ack_fire = (state == ST_REQ) && irq_ack;
   assign unused_wr = ^wr_data;

   always_comb begin
      win_id = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (elig[i]) win_id = 5'(i);
      end
   end

   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         ack_clr[i] = ack_fire && (irq_id == 5'(i));
      end
   end

   always_comb begin
      w1c = '0;
      if (wr_en && addr == ADDR_PEND) w1c = wr_data[NUM_SRC-1:0];
   end

   // a new edge wins over a clear landing on the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~w1c & ~ack_clr) | rise;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q   <= '0;
         status_q <= 1'b0;
      end else if (wr_en) begin
         unique case (1'b1)
            addr == ADDR_MASK:   mask_q   <= wr_data[NUM_SRC-1:0];
            addr == ADDR_STATUS: status_q <= wr_data[0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         irq_req <= 1'b0;
         irq_id  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_elig) begin
                  state   <= ST_REQ;
                  irq_req <= 1'b1;
                  irq_id  <= win_id;
               end
            end
            ST_REQ: begin
               if (irq_ack) begin
                  state   <= ST_SERVICE;
                  irq_req <= 1'b0;
               end else if (!any_elig) begin
                  state   <= ST_IDLE;
                  irq_req <= 1'b0;
               end else begin
                  irq_id  <= win_id;
               end
            end
            ST_SERVICE: begin
               if (irq_eret) state <= ST_IDLE;
            end
            default: begin
               state   <= ST_IDLE;
               irq_req <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      mask_w = '0;
      pend_w = '0;
      mask_w[NUM_SRC-1:0] = mask_q;
      pend_w[NUM_SRC-1:0] = pending;
   end

   always_comb begin
      rd_data = '0;
      case (addr)
         ADDR_MASK:   rd_data = mask_w;
         ADDR_PEND:   rd_data = pend_w;
         ADDR_CAUSE:  rd_data = {state == ST_SERVICE, 26'd0, irq_id};
         ADDR_STATUS: rd_data = {31'd0, status_q};
         default:     rd_data = '0;
      endcase
   end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: register table plus
// hand-timed sequences for capture, priority, FSM and reset.
module tb_irq_controller;
   import irq_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [7:0]  irq_in;
   logic        irq_req;
   logic [4:0]  irq_id;
   logic        irq_ack;
   logic        irq_eret;
   logic        wr_en;
   logic [1:0]  addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        we;
      logic [1:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
   } reg_vec_t;

   reg_vec_t vecs[6];

   irq_controller #(
      .NUM_SRC    (8),
      .SYNC_STAGES(2)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .irq_in  (irq_in),
      .irq_req (irq_req),
      .irq_id  (irq_id),
      .irq_ack (irq_ack),
      .irq_eret(irq_eret),
      .wr_en   (wr_en),
      .addr    (addr),
      .wr_data (wr_data),
      .rd_data (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rd_data;
   endtask

   task automatic chk_reg(input string nm, input logic [1:0] a,
                          input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      check(nm, d, exp);
   endtask

   task automatic chk_req(input string nm, input logic r,
                          input logic [4:0] id);
      check(nm, {26'd0, irq_req, irq_id}, {26'd0, r, id});
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      wr_en   = 1'b1;
      addr    = a;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
      wr_data = '0;
   endtask

   task automatic pulse_ack();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
   endtask

   task automatic pulse_eret();
      irq_eret = 1'b1;
      tick();
      irq_eret = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      irq_in   = '0;
      irq_ack  = 1'b0;
      irq_eret = 1'b0;
      wr_en    = 1'b0;
      addr     = '0;
      wr_data  = '0;

      vecs[0] = '{1'b1, ADDR_MASK,   32'hFFFF_FF5A, 32'h0000_005A};
      vecs[1] = '{1'b0, ADDR_MASK,   32'h0000_0000, 32'h0000_005A};
      vecs[2] = '{1'b1, ADDR_STATUS, 32'hFFFF_FFFE, 32'h0000_0000};
      vecs[3] = '{1'b1, ADDR_STATUS, 32'h0000_0003, 32'h0000_0001};
      vecs[4] = '{1'b1, ADDR_CAUSE,  32'hDEAD_BEEF, 32'h0000_0000};
      vecs[5] = '{1'b1, ADDR_PEND,   32'h0000_00FF, 32'h0000_0000};

      // reset state
      #3;
      chk_req("rst_req", 1'b0, 5'd0);
      chk_reg("rst_mask", ADDR_MASK, 32'h0);
      chk_reg("rst_pend", ADDR_PEND, 32'h0);
      chk_reg("rst_cause", ADDR_CAUSE, 32'h0);
      chk_reg("rst_status", ADDR_STATUS, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      repeat (4) tick();

      // register table
      for (int i = 0; i < 6; i++) begin
         if (vecs[i].we) wr(vecs[i].addr, vecs[i].data);
         else tick();
         chk_reg($sformatf("regvec%0d", i), vecs[i].addr, vecs[i].exp);
      end

      // capture latency: single source 3
      wr(ADDR_MASK, 32'hFF);
      irq_in[3] = 1'b1;
      repeat (3) tick();
      chk_reg("lat_pend_early", ADDR_PEND, 32'h0);
      tick();
      chk_reg("lat_pend", ADDR_PEND, 32'h08);
      chk_req("lat_req_early", 1'b0, 5'd0);
      tick();
      chk_req("lat_req", 1'b1, 5'd3);
      pulse_ack();
      chk_req("ack3_req", 1'b0, 5'd3);
      chk_reg("ack3_cause", ADDR_CAUSE, 32'h8000_0003);
      chk_reg("ack3_pend", ADDR_PEND, 32'h0);
      pulse_eret();
      chk_reg("eret3_cause", ADDR_CAUSE, 32'h0000_0003);
      irq_in = '0;
      repeat (4) tick();

      // priority, service accumulation, ignored handshakes
      irq_in[5] = 1'b1;
      irq_in[2] = 1'b1;
      repeat (5) tick();
      chk_req("prio_req", 1'b1, 5'd2);
      pulse_ack();
      chk_reg("prio_pend", ADDR_PEND, 32'h20);
      chk_reg("prio_cause", ADDR_CAUSE, 32'h8000_0002);
      irq_in[1] = 1'b1;
      tick();
      irq_in[1] = 1'b0;
      repeat (4) tick();
      chk_req("svc_req", 1'b0, 5'd2);
      chk_reg("svc_pend", ADDR_PEND, 32'h22);
      chk_reg("svc_cause", ADDR_CAUSE, 32'h8000_0002);
      pulse_ack();
      chk_reg("svc_ack_ign", ADDR_CAUSE, 32'h8000_0002);
      pulse_eret();
      chk_reg("svc_eret", ADDR_CAUSE, 32'h0000_0002);
      tick();
      chk_req("next_req1", 1'b1, 5'd1);
      pulse_eret();
      chk_req("req_eret_ign", 1'b1, 5'd1);
      pulse_ack();
      chk_reg("ack1_pend", ADDR_PEND, 32'h20);
      chk_reg("ack1_cause", ADDR_CAUSE, 32'h8000_0001);
      pulse_eret();
      tick();
      chk_req("next_req5", 1'b1, 5'd5);
      irq_ack  = 1'b1;
      irq_eret = 1'b1;
      tick();
      chk_reg("both_in_req", ADDR_CAUSE, 32'h8000_0005);
      chk_req("both_req", 1'b0, 5'd5);
      tick();
      irq_ack  = 1'b0;
      irq_eret = 1'b0;
      chk_reg("both_in_svc", ADDR_CAUSE, 32'h0000_0005);
      tick();
      chk_req("idle_req", 1'b0, 5'd5);
      chk_reg("idle_pend", ADDR_PEND, 32'h0);
      irq_in = '0;
      repeat (4) tick();

      // set beats W1C on the same edge, then mask drop in REQ
      irq_in[3] = 1'b1;
      repeat (3) tick();
      wr(ADDR_PEND, 32'h08);
      chk_reg("w1c_race", ADDR_PEND, 32'h08);
      tick();
      chk_req("race_req", 1'b1, 5'd3);
      wr(ADDR_MASK, 32'h0);
      tick();
      chk_req("mask_drop_req", 1'b0, 5'd3);
      chk_reg("mask_drop_pend", ADDR_PEND, 32'h08);
      chk_reg("mask_drop_cause", ADDR_CAUSE, 32'h0000_0003);
      wr(ADDR_PEND, 32'h08);
      chk_reg("w1c_clear", ADDR_PEND, 32'h0);
      wr(ADDR_MASK, 32'hFF);
      repeat (2) tick();
      chk_req("no_req", 1'b0, 5'd3);
      irq_in = '0;
      repeat (4) tick();

      // global enable gating
      wr(ADDR_STATUS, 32'h0);
      irq_in[4] = 1'b1;
      repeat (6) tick();
      chk_req("gen_off_req", 1'b0, 5'd3);
      chk_reg("gen_off_pend", ADDR_PEND, 32'h10);
      wr(ADDR_STATUS, 32'h1);
      tick();
      chk_req("gen_on_req", 1'b1, 5'd4);
      pulse_ack();
      pulse_eret();
      irq_in = '0;
      repeat (4) tick();

      // reset during service, source held high through release
      irq_in[0] = 1'b1;
      irq_in[6] = 1'b1;
      repeat (5) tick();
      chk_req("pre_rst_req", 1'b1, 5'd0);
      pulse_ack();
      chk_reg("pre_rst_pend", ADDR_PEND, 32'h40);
      chk_reg("pre_rst_cause", ADDR_CAUSE, 32'h8000_0000);
      irq_in[6] = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_req("mid_rst_req", 1'b0, 5'd0);
      chk_reg("mid_rst_cause", ADDR_CAUSE, 32'h0);
      chk_reg("mid_rst_pend", ADDR_PEND, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      chk_reg("post_rst_mask", ADDR_MASK, 32'h0);
      chk_reg("post_rst_status", ADDR_STATUS, 32'h0);
      wr(ADDR_MASK, 32'hFF);
      wr(ADDR_STATUS, 32'h1);
      repeat (8) tick();
      chk_req("held_high_req", 1'b0, 5'd0);
      chk_reg("held_high_pend", ADDR_PEND, 32'h0);
      irq_in[0] = 1'b0;
      repeat (4) tick();
      irq_in[0] = 1'b1;
      repeat (5) tick();
      chk_req("rearm_req", 1'b1, 5'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 The parameter NUM_SRC SHALL default to 8, range 1..32, and set the number of interrupt sources.
REQ-002 The parameter SYNC_STAGES SHALL default to 2, range 2..3, and set the synchronizer depth per source.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk  in  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-005 Port rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 Port irq_in  in  NUM_SRC  SHALL carry asynchronous level sources, rising edge = event.
REQ-007 Port irq_req  out  1  SHALL be the registered interrupt request to the CPU core.
REQ-008 Port irq_id  out  5  SHALL be the registered index of the source being requested/serviced.
REQ-009 Port irq_ack  in  1  SHALL be a one-cycle pulse from the core accepting the request.
REQ-010 Port irq_eret  in  1  SHALL be a one-cycle pulse from the core ending service.
REQ-011 Ports wr_en in 1, addr in 2, wr_data in 32 SHALL form the CPU register write port.
REQ-012 Port rd_data  out  32  SHALL combinationally return the register selected by addr.

Function
REQ-013 Register map SHALL be: 0 MASK (rw, 1 = enabled), 1 PENDING (r, write-1-to-clear), 2 CAUSE (r, bit31 = in service, bits4:0 = irq_id), 3 STATUS (rw, bit0 = global enable); unused bits read 0.
REQ-014 Each source SHALL pass SYNC_STAGES flops, then a one-flop edge detector; a 0->1 transition of the synchronized signal SHALL set its PENDING bit.
REQ-015 irq_in held high from edge N SHALL set PENDING at edge N+SYNC_STAGES+1.
REQ-016 A PENDING set and W1C clear of the same bit in one cycle SHALL leave the bit set.
REQ-017 Eligible = PENDING & MASK with STATUS.bit0 = 1; the winner SHALL be the lowest eligible index.
REQ-018 FSM states: IDLE, REQ, SERVICE.
REQ-019 IDLE -> REQ on the edge after any eligible source exists; irq_req = 1 and irq_id = winner from that edge.
REQ-020 In REQ, irq_id SHALL re-track the current winner each cycle until ack; if nothing is eligible any more (masked/cleared), return to IDLE with irq_req = 0.
REQ-021 REQ -> SERVICE on irq_ack: irq_req falls, irq_id frozen, that PENDING bit cleared the same edge, CAUSE.bit31 = 1.
REQ-022 SERVICE -> IDLE on irq_eret; no nesting, new events only accumulate in PENDING meanwhile.
REQ-023 irq_ack outside REQ and irq_eret outside SERVICE SHALL be ignored.
REQ-024 irq_ack and irq_eret asserted together SHALL resolve per current state only (one transition per cycle).

Reset
REQ-025 rst_n low SHALL asynchronously clear all synchronizer/edge flops, PENDING, MASK, STATUS, state (IDLE), irq_req, irq_id.
REQ-026 Reset mid-REQ/SERVICE SHALL drop irq_req the same instant and discard all pending events.
REQ-027 A source high across reset deassertion SHALL produce no event until it goes low and high again.

Structure
REQ-028 Package irq_pkg SHALL hold the FSM state type and the register address constants.
REQ-029 Sub-module irq_sync_edge (one source: synchronizer + edge detector, SYNC_STAGES parameter) SHALL be instantiated NUM_SRC times.

Verification (NUM_SRC=8, SYNC_STAGES=2)
REQ-030 MASK=0xFF, STATUS=1, irq_in[3] rises at edge 10 -> PENDING=0x08 at edge 13, irq_req=1 and irq_id=3 at edge 14.
REQ-031 irq_in[5] and [2] rise same cycle -> irq_id=2; ack -> PENDING=0x20; eret -> next request irq_id=5.
REQ-032 In SERVICE, irq_in[1] pulses -> irq_req stays 0, PENDING bit1 set, CAUSE=0x80000002 (if id 2 in service); after eret irq_id=1.
REQ-033 W1C of bit3 on the exact edge bit3 is set again -> PENDING bit3 remains 1.
REQ-034 MASK cleared while in REQ with only source 3 pending -> irq_req falls next edge, state IDLE, PENDING bit3 still 1.
REQ-035 rst_n low during SERVICE -> irq_req=0, CAUSE=0, PENDING=0 immediately; irq_in[0] held high through release -> no request.
